// File: rtl/audio_pdm_out.sv
// audio_pdm_out: consumer end of the 4-bit sample interface.
// Generates the sample-rate strobe, captures the settled mixer sample,
// fades the level in/out with a stepped gain ramp and drives a
// first-order sigma-delta bit stream onto the audio pin.
module audio_pdm_out #(
    parameter int CLK_DIV     = 1536,
    parameter int LATCH_DELAY = 5,
    parameter int RAMP_STEP   = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] sample,
    output logic       sample_ena,
    output logic       pdm_out,
    output logic [3:0] level_o,
    output logic       active
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       LATCH_LAST = 4'(LATCH_DELAY);
    localparam logic [7:0]       STEP_LAST  = 8'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN
    } state_t;

    // Scaled level: (c * (g + 1)) >> 4. The product never exceeds 240,
    // so the shifted result always fits in four bits.
    function automatic logic [3:0] scale_level(input logic [3:0] c, input logic [3:0] g);
        logic [8:0] prod;
        prod = {5'd0, c} * {4'd0, ({1'b0, g} + 5'd1)};
        return 4'(prod >> 4);
    endfunction

    // ------------------------------------------------------------------
    // Sample-rate divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             strobe_q;

    assign div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);

    // Free-running divider; the strobe is registered one cycle after the terminal count.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= '0;
            strobe_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            strobe_q  <= (div_cnt_q == DIV_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Sample capture, LATCH_DELAY cycles after the strobe cycle
    // ------------------------------------------------------------------
    logic       armed_q;
    logic [3:0] dly_q;
    logic [3:0] cap_q;
    logic [3:0] cap_d;
    logic       cap_en;

    // dly_q holds k during cycle S+k, so the capture fires at the end of S+LATCH_DELAY.
    assign cap_en = armed_q && (dly_q == LATCH_LAST);
    assign cap_d  = cap_en ? sample : cap_q;

    // Delay counter armed by the strobe; captures the mixer output once it has settled.
    always_ff @(posedge clock) begin
        if (reset) begin
            armed_q <= 1'b0;
            dly_q   <= 4'd0;
            cap_q   <= 4'd0;
        end else begin
            if (strobe_q) begin
                armed_q <= 1'b1;
                dly_q   <= 4'd1;
            end else if (cap_en) begin
                armed_q <= 1'b0;
                dly_q   <= 4'd0;
            end else if (armed_q) begin
                dly_q   <= dly_q + 4'd1;
            end
            cap_q <= cap_d;
        end
    end

    // ------------------------------------------------------------------
    // Gain ramp FSM
    // ------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [3:0] gain_q;
    logic [3:0] gain_d;
    logic [7:0] step_q;
    logic [7:0] step_d;
    logic [7:0] step_inc;

    assign step_inc = step_q + 8'd1;

    // Next-state logic: an enable change takes priority over a pending gain step.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        step_d  = step_q;
        case (state_q)
            ST_OFF: begin
                gain_d = 4'd0;
                if (enable) begin
                    state_d = ST_RAMP_UP;
                    step_d  = 8'd0;
                end
            end
            ST_RAMP_UP: begin
                if (!enable) begin
                    state_d = ST_RAMP_DOWN;
                    step_d  = 8'd0;
                end else if (gain_q == 4'd15) begin
                    // Reversed out of a fade-down before its first step: already at full gain.
                    state_d = ST_ON;
                    step_d  = 8'd0;
                end else if (strobe_q) begin
                    if (step_inc == STEP_LAST) begin
                        step_d = 8'd0;
                        gain_d = gain_q + 4'd1;
                        if (gain_q == 4'd14) begin
                            state_d = ST_ON;
                        end
                    end else begin
                        step_d = step_inc;
                    end
                end
            end
            ST_ON: begin
                gain_d = 4'd15;
                if (!enable) begin
                    state_d = ST_RAMP_DOWN;
                    step_d  = 8'd0;
                end
            end
            ST_RAMP_DOWN: begin
                if (enable) begin
                    state_d = ST_RAMP_UP;
                    step_d  = 8'd0;
                end else if (gain_q == 4'd0) begin
                    // Reversed out of a fade-up before its first step: already silent.
                    state_d = ST_OFF;
                    step_d  = 8'd0;
                end else if (strobe_q) begin
                    if (step_inc == STEP_LAST) begin
                        step_d = 8'd0;
                        gain_d = gain_q - 4'd1;
                        if (gain_q == 4'd1) begin
                            state_d = ST_OFF;
                        end
                    end else begin
                        step_d = step_inc;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                gain_d  = 4'd0;
                step_d  = 8'd0;
            end
        endcase
    end

    logic active_q;

    // FSM state register; active is registered alongside the state it describes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_OFF;
            gain_q   <= 4'd0;
            step_q   <= 8'd0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            step_q   <= step_d;
            active_q <= (state_d != ST_OFF);
        end
    end

    // ------------------------------------------------------------------
    // Level scaling
    // ------------------------------------------------------------------
    logic [3:0] level_q;
    logic [3:0] level_d;

    // Built from next-state cap/gain so the level is valid in the cycle right after
    // the capture edge or gain step, with no extra lag.
    assign level_d = (state_d == ST_OFF) ? 4'd0 : scale_level(cap_d, gain_d);

    // Level register feeding the modulator.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= 4'd0;
        end else begin
            level_q <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // First-order sigma-delta modulator
    // ------------------------------------------------------------------
    logic [3:0] acc_q;
    logic       pdm_q;
    logic [4:0] mod_sum;

    assign mod_sum = {1'b0, acc_q} + {1'b0, level_q};

    // Accumulator overflow is the output bit: density is level/16, exact over 16 cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= 4'd0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= mod_sum[3:0];
            pdm_q <= mod_sum[4];
        end
    end

    assign sample_ena = strobe_q;
    assign pdm_out    = pdm_q;
    assign level_o    = level_q;
    assign active     = active_q;

endmodule

// File: tb/tb_audio_pdm_out.sv
// Self-checking bench for audio_pdm_out: divider, capture timing, gain ramp,
// reversal, PDM density and mid-stream reset, with a level scoreboard.
module tb_audio_pdm_out;

    localparam int CLK_DIV     = 1536;
    localparam int LATCH_DELAY = 5;
    localparam int RAMP_STEP   = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] sample;
    logic       sample_ena;
    logic       pdm_out;
    logic [3:0] level_o;
    logic       active;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    bit req_active = 1'b0;

    audio_pdm_out #(
        .CLK_DIV    (CLK_DIV),
        .LATCH_DELAY(LATCH_DELAY),
        .RAMP_STEP  (RAMP_STEP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sample    (sample),
        .sample_ena(sample_ena),
        .pdm_out   (pdm_out),
        .level_o   (level_o),
        .active    (active)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_level(input int c, input int g);
        return (c * (g + 1)) / 16;
    endfunction

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (req_active) check_eq("active_hold", int'(active), 1);
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Return in the strobe cycle S (bounded wait).
    task automatic wait_strobe();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < CLK_DIV + 8 && !seen; k++) begin
            tick();
            seen = sample_ena;
        end
        check_eq("strobe_seen", int'(seen), 1);
    endtask

    task automatic sb_pop(input string tag);
        int e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check_eq(tag, int'(level_o), e);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pdm_bits[48];
        int vals[3];
        int gap;
        bit seen;

        reset  = 1'b1;
        enable = 1'b0;
        sample = 4'd0;
        adv(3);
        check_eq("rst_ena",    int'(sample_ena), 0);
        check_eq("rst_pdm",    int'(pdm_out),    0);
        check_eq("rst_level",  int'(level_o),    0);
        check_eq("rst_active", int'(active),     0);
        reset = 1'b0;

        // Divider with enable low
        for (int n = 1; n <= 3 * CLK_DIV + 4; n++) begin
            tick();
            check_eq("div_ena", int'(sample_ena), int'(n % CLK_DIV == 0));
            check_eq("div_quiet", int'({pdm_out, level_o, active}), 0);
        end

        // Ramp up with sample 15, one gain step per strobe
        sample = 4'd15;
        enable = 1'b1;
        tick();
        check_eq("ramp_start_active", int'(active), 1);
        check_eq("ramp_start_level", int'(level_o), 0);
        req_active = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            wait_strobe();
            exp_q.push_back(exp_level(15, k));
            adv(6);
            sb_pop("ramp_up_lvl");
        end
        wait_strobe();
        exp_q.push_back(15);
        adv(6);
        sb_pop("on_hold");

        // Capture timing at full gain
        sample = 4'd3;
        wait_strobe();
        exp_q.push_back(3);
        adv(6);
        sb_pop("cap_base");
        wait_strobe();
        adv(5);
        check_eq("cap_pre", int'(level_o), 3);
        sample = 4'd9;
        exp_q.push_back(9);
        adv(1);
        sb_pop("cap_at_s5");
        sample = 4'd3;
        wait_strobe();
        exp_q.push_back(3);
        adv(6);
        sb_pop("cap_restore");
        wait_strobe();
        adv(6);
        sample = 4'd9;
        exp_q.push_back(3);
        adv(1);
        sb_pop("cap_at_s6_ignored");

        // PDM density at constant level
        vals[0] = 5; vals[1] = 0; vals[2] = 15;
        for (int v = 0; v < 3; v++) begin
            sample = 4'(vals[v]);
            wait_strobe();
            adv(7);
            pdm_bits[0] = pdm_out;
            for (int i = 1; i < 48; i++) begin
                tick();
                pdm_bits[i] = pdm_out;
            end
            for (int w = 0; w <= 32; w++) begin
                int ones;
                ones = 0;
                for (int j = 0; j < 16; j++) ones += int'(pdm_bits[w + j]);
                check_eq("pdm_density", ones, vals[v]);
            end
        end

        // Mid-stream reset while ON at level 12
        sample = 4'd12;
        wait_strobe();
        exp_q.push_back(12);
        adv(6);
        sb_pop("pre_reset_lvl");
        req_active = 1'b0;
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check_eq("mrst_ena",    int'(sample_ena), 0);
        check_eq("mrst_pdm",    int'(pdm_out),    0);
        check_eq("mrst_level",  int'(level_o),    0);
        check_eq("mrst_active", int'(active),     0);
        reset = 1'b0;
        gap  = -1;
        seen = 1'b0;
        for (int n = 1; n <= CLK_DIV + 8 && !seen; n++) begin
            tick();
            if (sample_ena) begin
                seen = 1'b1;
                gap  = n;
            end
        end
        check_eq("mrst_gap", gap, CLK_DIV);
        check_eq("mrst_off", int'(active), 0);

        // Reversal: up to 7, down two steps, back up from 5
        sample = 4'd15;
        enable = 1'b1;
        tick();
        check_eq("rev_start_active", int'(active), 1);
        req_active = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            wait_strobe();
            exp_q.push_back(exp_level(15, k));
            adv(6);
            sb_pop("rev_up");
        end
        enable = 1'b0;
        tick();
        check_eq("rev_turn", int'(level_o), 7);
        for (int g = 6; g >= 5; g--) begin
            wait_strobe();
            exp_q.push_back(exp_level(15, g));
            adv(6);
            sb_pop("rev_down");
        end
        enable = 1'b1;
        tick();
        check_eq("rev_back", int'(level_o), 5);
        for (int g = 6; g <= 7; g++) begin
            wait_strobe();
            exp_q.push_back(exp_level(15, g));
            adv(6);
            sb_pop("rev_up2");
        end

        // Fade down to OFF
        enable = 1'b0;
        tick();
        for (int g = 6; g >= 1; g--) begin
            wait_strobe();
            exp_q.push_back(exp_level(15, g));
            adv(6);
            sb_pop("down_lvl");
        end
        wait_strobe();
        check_eq("off_prev_active", int'(active), 1);
        req_active = 1'b0;
        tick();
        check_eq("off_active", int'(active), 0);
        check_eq("off_level", int'(level_o), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
